// File: rtl/hyperbus_trx_arbiter.sv
// HyperBus transaction arbiter: round-robin grant of NumReq requesters onto
// one PHY transaction channel with chip decode, CS-high gap and watchdog.
module hyperbus_trx_arbiter #(
   parameter int NumReq        = 2,
   parameter int NumChips      = 2,
   parameter int AddrWidth     = 32,
   parameter int LenWidth      = 16,
   parameter int ChipAddrBits  = 23,
   parameter int GapWidth      = 4,
   parameter int TimeoutCycles = 4096,
   localparam int IdWidth      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumReq-1:0]                   req_valid_i,
   output logic [NumReq-1:0]                   req_ready_o,
   input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
   input  logic [NumReq-1:0]                   req_write_i,
   input  logic [NumReq-1:0][LenWidth-1:0]     req_len_i,
   output logic                                trx_valid_o,
   input  logic                                trx_ready_i,
   output logic [AddrWidth-1:0]                trx_addr_o,
   output logic                                trx_write_o,
   output logic [LenWidth-1:0]                 trx_len_o,
   output logic [NumChips-1:0]                 trx_cs_o,
   output logic [IdWidth-1:0]                  trx_id_o,
   input  logic                                trx_done_i,
   input  logic [GapWidth-1:0]                 cs_gap_i,
   output logic                                busy_o,
   output logic                                timeout_o,
   output logic                                decerr_o,
   output logic [IdWidth-1:0]                  err_id_o
);

   // One extra index bit so addresses just past the last chip are caught.
   localparam int ChipIdxW = $clog2(NumChips) + 1;
   localparam int WdWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam int WdLimit  = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
   localparam bit WdEnable = (TimeoutCycles > 0);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      GAP
   } state_t;

   state_t               state_q;
   logic [IdWidth-1:0]   rr_q;
   logic [IdWidth-1:0]   win;
   logic [IdWidth-1:0]   rr_next;
   logic                 found;
   logic [ChipIdxW-1:0]  chip_idx;
   logic                 dec_ok;
   logic [NumChips-1:0]  win_cs;
   logic [WdWidth-1:0]   wd_q;
   logic [GapWidth-1:0]  gap_q;
   logic                 expire;

   // Round-robin search: first valid requester at or above the pointer.
   always_comb begin
      int s;
      logic [IdWidth-1:0] cand;
      s     = 0;
      cand  = '0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NumReq; k++) begin
         s = int'(rr_q) + k;
         if (s >= NumReq) s = s - NumReq;
         cand = IdWidth'(s);
         if (!found && req_valid_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign rr_next  = (win == IdWidth'(NumReq - 1)) ? '0 : win + IdWidth'(1);
   assign chip_idx = req_addr_i[win][ChipAddrBits +: ChipIdxW];
   assign dec_ok   = int'(chip_idx) < NumChips;
   assign win_cs   = NumChips'(1) << chip_idx;
   assign expire   = WdEnable && (wd_q == WdWidth'(WdLimit));

   // Acknowledge the winner in the same cycle; silent while in reset.
   always_comb begin
      req_ready_o = '0;
      if (!rst_i && state_q == IDLE && found) req_ready_o[win] = 1'b1;
   end

   // Transaction FSM with all PHY-facing outputs registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         wd_q        <= '0;
         gap_q       <= '0;
         trx_valid_o <= 1'b0;
         trx_addr_o  <= '0;
         trx_write_o <= 1'b0;
         trx_len_o   <= '0;
         trx_cs_o    <= '0;
         trx_id_o    <= '0;
         busy_o      <= 1'b0;
         timeout_o   <= 1'b0;
         decerr_o    <= 1'b0;
         err_id_o    <= '0;
      end else begin
         timeout_o <= 1'b0;
         decerr_o  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  rr_q <= rr_next;
                  if (dec_ok) begin
                     trx_addr_o  <= req_addr_i[win];
                     trx_write_o <= req_write_i[win];
                     trx_len_o   <= req_len_i[win];
                     trx_cs_o    <= win_cs;
                     trx_id_o    <= win;
                     trx_valid_o <= 1'b1;
                     busy_o      <= 1'b1;
                     state_q     <= ISSUE;
                  end else begin
                     // Acknowledged but dropped: report and stay idle.
                     decerr_o <= 1'b1;
                     err_id_o <= win;
                  end
               end
            end
            ISSUE: begin
               if (trx_ready_i) begin
                  trx_valid_o <= 1'b0;
                  wd_q        <= '0;
                  state_q     <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (trx_done_i || expire) begin
                  // A real completion in the expiry cycle is not a timeout.
                  if (!trx_done_i) begin
                     timeout_o <= 1'b1;
                     err_id_o  <= trx_id_o;
                  end
                  if (cs_gap_i == '0) begin
                     busy_o  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     gap_q   <= cs_gap_i;
                     state_q <= GAP;
                  end
               end else begin
                  wd_q <= wd_q + WdWidth'(1);
               end
            end
            GAP: begin
               if (gap_q <= GapWidth'(1)) begin
                  busy_o  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q - GapWidth'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
